// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small input FIFO: programmable bit period, optional
// parity, one or two stop bits, back-to-back frames while words are queued.
module uart_tx_fifo #(
  parameter int DATAWIDTH  = 8,
  parameter int CLKDIV     = 16,
  parameter int PARITY     = 0,
  parameter int STOPBITS   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATAWIDTH-1:0] DATA,
  input  logic                 DATARDY,
  output logic                 FULL,
  output logic                 READ,
  output logic                 BUSY,
  output logic                 TX
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int DIVW = $clog2(CLKDIV);
  localparam int BCW  = 4;
  // Reserved encoding 3 falls through to "no parity".
  localparam bit USE_PAR = (PARITY == 1) || (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state, state_next;
  logic [DATAWIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count, count_next;
  logic                 push, pop, empty;
  logic [DIVW-1:0]      div, div_next;
  logic                 div_end;
  logic [BCW-1:0]       bit_cnt, bit_cnt_next;
  logic [DATAWIDTH-1:0] shift, shift_next;
  logic                 par, par_next;
  logic                 tx_next;

  function automatic logic parity_of(input logic [DATAWIDTH-1:0] d);
    return (PARITY == 1) ? ~(^d) : ^d;
  endfunction

  assign push       = DATARDY && !FULL;
  assign empty      = (count == '0);
  assign count_next = count + CW'(push) - CW'(pop);
  assign div_end    = (div == DIVW'(CLKDIV - 1));

  always_comb begin
    state_next   = state;
    div_next     = div_end ? '0 : div + 1'b1;
    bit_cnt_next = bit_cnt;
    shift_next   = shift;
    par_next     = par;
    pop          = 1'b0;
    case (state)
      S_IDLE: begin
        div_next = '0;
        if (!empty) begin
          pop          = 1'b1;
          bit_cnt_next = '0;
          state_next   = S_START;
        end
      end
      S_START: begin
        if (div_end) state_next = S_DATA;
      end
      S_DATA: begin
        if (div_end) begin
          shift_next = shift >> 1;
          if (bit_cnt == BCW'(DATAWIDTH - 1)) begin
            bit_cnt_next = '0;
            state_next   = USE_PAR ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (div_end) state_next = S_STOP;
      end
      S_STOP: begin
        if (div_end) begin
          if (bit_cnt == BCW'(STOPBITS - 1)) begin
            bit_cnt_next = '0;
            // Chain straight into the next start bit when more words wait.
            if (!empty) begin
              pop        = 1'b1;
              state_next = S_START;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (pop) begin
      shift_next = mem[rd_ptr];
      par_next   = parity_of(mem[rd_ptr]);
    end
    // TX is registered from the next-state view so it changes with the state.
    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_next[0];
      S_PARITY: tx_next = par_next;
      default:  tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      div     <= '0;
      bit_cnt <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      FULL    <= 1'b0;
      READ    <= 1'b0;
      BUSY    <= 1'b0;
      TX      <= 1'b1;
    end else begin
      state   <= state_next;
      div     <= div_next;
      bit_cnt <= bit_cnt_next;
      count   <= count_next;
      FULL    <= (count_next == CW'(FIFO_DEPTH));
      READ    <= push;
      BUSY    <= (state_next != S_IDLE);
      TX      <= tx_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= DATA;
    shift <= shift_next;
    par   <= par_next;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four parameterisations on one clock, TX/BUSY/READ/FULL
// captured cycle by cycle and compared against hand-built frame waveforms.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_a, data_o, data_e;
  logic [8:0] data_w;
  logic       rdy_a, rdy_o, rdy_e, rdy_w;
  logic       full_a, read_a, busy_a, tx_a;
  logic       full_o, read_o, busy_o, tx_o;
  logic       full_e, read_e, busy_e, tx_e;
  logic       full_w, read_w, busy_w, tx_w;

  int compared = 0;
  int mismatched = 0;

  logic [255:0] cap_tx_a, cap_busy_a, cap_read_a, cap_full_a;
  logic [255:0] cap_tx_o, cap_busy_o, cap_tx_e, cap_busy_e, cap_tx_w, cap_busy_w;
  logic [255:0] cap_read_o, cap_read_e, cap_read_w;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATAWIDTH(8), .CLKDIV(4), .PARITY(0), .STOPBITS(1), .FIFO_DEPTH(4)) u_a (
    .CLK(clk), .RST(rst), .DATA(data_a), .DATARDY(rdy_a),
    .FULL(full_a), .READ(read_a), .BUSY(busy_a), .TX(tx_a));
  uart_tx_fifo #(.DATAWIDTH(8), .CLKDIV(4), .PARITY(1), .STOPBITS(1), .FIFO_DEPTH(4)) u_o (
    .CLK(clk), .RST(rst), .DATA(data_o), .DATARDY(rdy_o),
    .FULL(full_o), .READ(read_o), .BUSY(busy_o), .TX(tx_o));
  uart_tx_fifo #(.DATAWIDTH(8), .CLKDIV(4), .PARITY(2), .STOPBITS(1), .FIFO_DEPTH(4)) u_e (
    .CLK(clk), .RST(rst), .DATA(data_e), .DATARDY(rdy_e),
    .FULL(full_e), .READ(read_e), .BUSY(busy_e), .TX(tx_e));
  uart_tx_fifo #(.DATAWIDTH(9), .CLKDIV(4), .PARITY(0), .STOPBITS(2), .FIFO_DEPTH(4)) u_w (
    .CLK(clk), .RST(rst), .DATA(data_w), .DATARDY(rdy_w),
    .FULL(full_w), .READ(read_w), .BUSY(busy_w), .TX(tx_w));

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Sample index k is taken 1 time unit after rising edge k of the test.
  task automatic tick(input int k);
    @(posedge clk);
    #1;
    cap_tx_a[8'(k)]   = tx_a;   cap_busy_a[8'(k)] = busy_a;
    cap_read_a[8'(k)] = read_a; cap_full_a[8'(k)] = full_a;
    cap_tx_o[8'(k)]   = tx_o;   cap_busy_o[8'(k)] = busy_o; cap_read_o[8'(k)] = read_o;
    cap_tx_e[8'(k)]   = tx_e;   cap_busy_e[8'(k)] = busy_e; cap_read_e[8'(k)] = read_e;
    cap_tx_w[8'(k)]   = tx_w;   cap_busy_w[8'(k)] = busy_w; cap_read_w[8'(k)] = read_w;
  endtask

  task automatic clear_caps();
    cap_tx_a = '0; cap_busy_a = '0; cap_read_a = '0; cap_full_a = '0;
    cap_tx_o = '0; cap_busy_o = '0; cap_read_o = '0;
    cap_tx_e = '0; cap_busy_e = '0; cap_read_e = '0;
    cap_tx_w = '0; cap_busy_w = '0; cap_read_w = '0;
  endtask

  // Expected TX over n samples: frame bits (first bit in bit 0) at 4 cycles each from index off.
  function automatic logic [255:0] wave(input logic [63:0] bits, input int nbits, input int off,
                                        input int n);
    logic [255:0] w = '0;
    for (int c = 0; c < n; c++)
      w[8'(c)] = (c >= off && c < off + nbits * 4) ? bits[6'((c - off) / 4)] : 1'b1;
    return w;
  endfunction

  function automatic logic [255:0] ones(input int lo, input int hi, input int n);
    logic [255:0] w = '0;
    for (int c = 0; c < n; c++) w[8'(c)] = (c >= lo && c <= hi);
    return w;
  endfunction

  function automatic logic [9:0] frm8(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rdy_a = 1'b0; rdy_o = 1'b0; rdy_e = 1'b0; rdy_w = 1'b0;
    data_a = '0; data_o = '0; data_e = '0; data_w = '0;
    #12;
    check("reset_tx",   256'(tx_a),   256'(1'b1));
    check("reset_busy", 256'(busy_a), 256'(1'b0));
    check("reset_read", 256'(read_a), 256'(1'b0));
    check("reset_full", 256'(full_a), 256'(1'b0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_tx_all", 256'({tx_a, tx_o, tx_e, tx_w}), 256'(4'b1111));

    // Single frames on all four instances at once.
    clear_caps();
    data_a = 8'hA5; data_o = 8'h07; data_e = 8'h07; data_w = 9'h1FF;
    rdy_a = 1'b1; rdy_o = 1'b1; rdy_e = 1'b1; rdy_w = 1'b1;
    tick(0);
    rdy_a = 1'b0; rdy_o = 1'b0; rdy_e = 1'b0; rdy_w = 1'b0;
    data_a = 8'h00; data_o = 8'hFF; data_e = 8'hFF; data_w = 9'h000;
    for (int k = 1; k < 56; k++) tick(k);
    check("a5_tx",     cap_tx_a,   wave(64'(10'b1101001010), 10, 1, 56));
    check("a5_busy",   cap_busy_a, ones(1, 40, 56));
    check("a5_read",   cap_read_a, ones(0, 0, 56));
    check("odd_tx",    cap_tx_o,   wave(64'(11'b10000001110), 11, 1, 56));
    check("odd_busy",  cap_busy_o, ones(1, 44, 56));
    check("odd_read",  cap_read_o, ones(0, 0, 56));
    check("even_tx",   cap_tx_e,   wave(64'(11'b11000001110), 11, 1, 56));
    check("even_busy", cap_busy_e, ones(1, 44, 56));
    check("w9s2_tx",   cap_tx_w,   wave(64'(12'b111111111110), 12, 1, 56));
    check("w9s2_busy", cap_busy_w, ones(1, 48, 56));
    check("w9s2_read", cap_read_w, ones(0, 0, 56));

    // Two stop bits, then the next queued frame follows immediately.
    clear_caps();
    data_w = 9'h1FF; rdy_w = 1'b1;
    tick(0);
    data_w = 9'h000;
    tick(1);
    rdy_w = 1'b0;
    for (int k = 2; k < 110; k++) tick(k);
    check("b2b_w_tx",   cap_tx_w,   wave(64'({12'b110000000000, 12'b111111111110}), 24, 1, 110));
    check("b2b_w_busy", cap_busy_w, ones(1, 96, 110));

    // Overflow: six consecutive pushes from idle, the sixth is dropped.
    clear_caps();
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: data_a = 8'h01;
        1: data_a = 8'h80;
        2: data_a = 8'hFF;
        3: data_a = 8'h00;
        4: data_a = 8'h5A;
        default: data_a = 8'hC3;
      endcase
      rdy_a = 1'b1;
      tick(k);
    end
    rdy_a = 1'b0;
    for (int k = 6; k < 220; k++) tick(k);
    check("ovf_read", cap_read_a, ones(0, 4, 220));
    check("ovf_full", cap_full_a, ones(4, 40, 220));
    check("ovf_tx", cap_tx_a,
          wave(64'({frm8(8'h5A), frm8(8'h00), frm8(8'hFF), frm8(8'h80), frm8(8'h01)}), 50, 1, 220));
    check("ovf_busy", cap_busy_a, ones(1, 200, 220));

    // Reset during data bit 3 with two words still queued.
    clear_caps();
    for (int k = 0; k < 3; k++) begin
      data_a = (k == 0) ? 8'h00 : ((k == 1) ? 8'h11 : 8'h22);
      rdy_a = 1'b1;
      tick(k);
    end
    rdy_a = 1'b0;
    for (int k = 3; k < 19; k++) tick(k);
    check("prerst_tx", cap_tx_a, wave(64'(frm8(8'h00)), 10, 1, 19));
    rst = 1'b1;
    #1;
    check("midrst_tx",   256'(tx_a),   256'(1'b1));
    check("midrst_busy", 256'(busy_a), 256'(1'b0));
    check("midrst_full", 256'(full_a), 256'(1'b0));
    @(posedge clk); #1;
    rst = 1'b0;
    clear_caps();
    for (int k = 0; k < 60; k++) tick(k);
    check("postrst_tx",   cap_tx_a,   wave(64'd0, 0, 0, 60));
    check("postrst_busy", cap_busy_a, 256'd0);
    check("postrst_read", cap_read_a, 256'd0);
    clear_caps();
    data_a = 8'h3C; rdy_a = 1'b1;
    tick(0);
    rdy_a = 1'b0;
    for (int k = 1; k < 50; k++) tick(k);
    check("recover_tx",   cap_tx_a,   wave(64'(frm8(8'h3C)), 10, 1, 50));
    check("recover_busy", cap_busy_a, ones(1, 40, 50));

    // Push on the same edge as a pop with two words queued.
    clear_caps();
    for (int k = 0; k < 250; k++) begin
      rdy_a = 1'b0;
      case (k)
        0:  begin data_a = 8'h12; rdy_a = 1'b1; end
        1:  begin data_a = 8'h34; rdy_a = 1'b1; end
        2:  begin data_a = 8'h56; rdy_a = 1'b1; end
        41: begin data_a = 8'h78; rdy_a = 1'b1; end
        42: begin data_a = 8'h9A; rdy_a = 1'b1; end
        43: begin data_a = 8'hBC; rdy_a = 1'b1; end
        default: data_a = 8'hEE;
      endcase
      tick(k);
    end
    rdy_a = 1'b0;
    check("simul_read", cap_read_a, ones(0, 2, 250) | ones(41, 43, 250));
    check("simul_full", cap_full_a, ones(43, 80, 250));
    check("simul_tx", cap_tx_a,
          wave(64'({frm8(8'hBC), frm8(8'h9A), frm8(8'h78), frm8(8'h56), frm8(8'h34), frm8(8'h12)}),
               60, 1, 250));
    check("simul_busy", cap_busy_a, ones(1, 240, 250));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an input FIFO, programmable bit period, optional parity and one or two stop bits. It is the next-generation serialiser in the UART library. A producer pushes words through a valid/full handshake, and the block emits back-to-back asynchronous frames on TX, LSB first, with no idle gap while words are queued.

## Interface
- DATAWIDTH, 8: data bits per frame; legal 5..9.
- CLKDIV, 16: CLK cycles per serial bit; legal ≥ 2.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOPBITS, 1: stop bits per frame; legal 1 or 2.
- FIFO_DEPTH, 4: input FIFO entries; power of two, ≥ 2.
- CLK  input  1  single clock; all logic on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- DATA  input  DATAWIDTH  word to transmit; sampled when DATARDY=1 and FULL=0.
- DATARDY  input  1  producer has a valid word on DATA.
- FULL  output  1  FIFO full; pushes are ignored while high.
- READ  output  1  one-cycle registered pulse, the cycle after a word is accepted.
- BUSY  output  1  a frame is in progress (any state other than IDLE).
- TX  output  1  serial line; idles high.

## Operation
- Push: at any rising edge with DATARDY=1 and FULL=0, write DATA to the FIFO tail and set READ=1 for the next cycle.
  - A push while FULL=1 is dropped silently, and READ stays 0.
- FIFO count width: clog2(FIFO_DEPTH)+1.
  - FULL = (count == FIFO_DEPTH), registered.
  - The occupancy of the next cycle is count + push − pop.
  - A simultaneous push and pop leaves count unchanged.
  - A pop from an empty FIFO never occurs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TX=1. If the FIFO is non-empty, pop the head into the shift register, compute parity, clear the bit counter and the divider, then go to START.
  - START: TX=0 for CLKDIV cycles, then go to DATA.
  - DATA: TX = shift[0] for CLKDIV cycles, then shift right. After DATAWIDTH bits, go to PARITY if PARITY≠0, else STOP.
  - PARITY: TX = parity bit for CLKDIV cycles, then go to STOP.
    - Even parity bit = XOR of the data bits.
    - Odd parity bit = its inverse.
  - STOP: TX=1 for STOPBITS×CLKDIV cycles. At the end of the last stop bit:
    - if the FIFO is non-empty, pop and go directly to START (no idle cycle);
    - otherwise go to IDLE.
- The divider counts 0..CLKDIV−1 and wraps. A bit ends on the cycle the divider equals CLKDIV−1.
- Reserved PARITY encodings (3) behave as none.
- DATA is not required to be stable after acceptance.

## Timing
- Reset values (asynchronous): TX=1, BUSY=0, READ=0, FULL=0, FIFO empty, FSM in IDLE, divider 0, bit counter 0.
- Reset mid-frame: TX returns high immediately, and the frame and all queued words are discarded.
- Latency: a word accepted at edge E0 while the block is idle and the FIFO is empty is popped at E0+1. TX falls and BUSY rises after E0+1.
- Frame length: CLKDIV×(1 + DATAWIDTH + (PARITY≠0) + STOPBITS) cycles, from the TX falling edge to the first cycle TX may fall again.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- BUSY stays high continuously between back-to-back frames. It falls the cycle after the final stop bit if the FIFO is empty.
- TX is a registered output: no combinational path from any input to TX.

## Test plan
- Single word, CLKDIV=4, PARITY=0, STOPBITS=1, DATA=0xA5:
  - TX = 0,1,0,1,0,0,1,0,1,1, each bit held exactly 4 cycles (40 cycles total).
  - BUSY is high for 40 cycles; READ pulses once.
- Parity, DATA=0x07:
  - PARITY=2 (even): parity bit = 1.
  - PARITY=1 (odd): parity bit = 0.
  - Frame is 44 cycles at CLKDIV=4.
- STOPBITS=2, DATAWIDTH=9, DATA=0x1FF: start low, nine 1s, then 2×CLKDIV high cycles before the next start bit can begin.
- FIFO overflow, FIFO_DEPTH=4, DATARDY held high for 6 consecutive cycles with words W1..W6 from idle:
  - W1..W5 are accepted (W1 is popped at once) and FULL rises after W5.
  - W6 is dropped, with no READ pulse.
  - TX carries W1..W5 back-to-back with no idle cycles between frames.
- Reset mid-frame: assert RST during data bit 3 of a frame with 2 words queued.
  - TX=1, BUSY=0 and FULL=0 immediately after RST asserts.
  - After release, no further frames are sent until a new push.
- Simultaneous push and pop: with count=2, push on the same edge a frame completes. Count stays 2, FULL stays 0, and the next frame starts with no gap.
